// File: rtl/modulus_sched_if.sv
// Request/response bundle for the shared modulus/divide sequencer.
// master = requesters plus result consumer, slave = the sequencer.
interface modulus_sched_if #(parameter int W = 4);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dbz;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );
endinterface

// File: rtl/modulus_sched.sv
// Round-robin two-requester scheduler around one iterative restoring divider.
// Latency: W+1 cycles from accept to rsp_valid (1 cycle when the divisor is zero).
// Backpressure: result held in DONE until rsp_ready; no request is accepted until back in IDLE.
module modulus_sched #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    modulus_sched_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nx;
    logic          last;
    logic          grant;
    logic          acc;
    logic          done_step;
    logic          id_r;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo, rem, b_r;
    logic [W-1:0]  a_sel, b_sel;
    logic [W-1:0]  quo_nx, rem_nx;
    logic [W:0]    s, diff;
    logic          ge;

    // Both pending: serve whoever was not served last; otherwise the only one pending.
    assign grant = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;

    assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant;
    assign bus.req1_ready = (state == IDLE) & bus.req1_valid &  grant;
    assign acc            = bus.req0_ready | bus.req1_ready;
    assign a_sel          = grant ? bus.req1_a : bus.req0_a;
    assign b_sel          = grant ? bus.req1_b : bus.req0_b;
    assign bus.rsp_valid  = (state == DONE);

    // Partial remainder stays below the divisor, so W bits hold it between steps.
    assign s         = {rem, quo[W-1]};
    assign ge        = (s >= {1'b0, b_r});
    assign diff      = s - {1'b0, b_r};
    assign rem_nx    = ge ? diff[W-1:0] : s[W-1:0];
    assign quo_nx    = {quo[W-2:0], ge};
    assign done_step = (cnt == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc) state_nx = (b_sel == '0) ? DONE : CALC;
            CALC:    if (done_step) state_nx = DONE;
            DONE:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= 1'b1;
            id_r        <= 1'b0;
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            b_r         <= '0;
            bus.rsp_id  <= 1'b0;
            bus.rsp_q   <= '0;
            bus.rsp_r   <= '0;
            bus.rsp_dbz <= 1'b0;
        end else if (acc) begin
            b_r  <= b_sel;
            id_r <= grant;
            last <= grant;
            if (b_sel == '0) begin
                bus.rsp_q   <= '1;
                bus.rsp_r   <= a_sel;
                bus.rsp_dbz <= 1'b1;
                bus.rsp_id  <= grant;
            end else begin
                rem <= '0;
                quo <= a_sel;
                cnt <= '0;
            end
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (done_step) begin
                bus.rsp_q   <= quo_nx;
                bus.rsp_r   <= rem_nx;
                bus.rsp_dbz <= 1'b0;
                bus.rsp_id  <= id_r;
            end
        end
    end
endmodule

// File: tb/tb_modulus_sched.sv
// Scoreboard bench: accepts are predicted from round-robin rules and plain / and %.
module tb_modulus_sched;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    modulus_sched_if #(.W(W)) bus();
    modulus_sched #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic busy = 1'b0, last = 1'b1, seen = 1'b0, hold = 1'b0;
    logic acc0 = 1'b0, acc1 = 1'b0, g_exp = 1'b0;
    logic [W-1:0] h_q, h_r;
    logic h_id, h_dbz;
    int   rdy_mode = 0;
    logic manual_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        exp_t e;
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        e.id = id;
        if (bi == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.due = c + 1;
        end else begin
            e.q = W'(ai / bi); e.r = W'(ai % bi); e.dbz = 1'b0; e.due = c + W + 1;
        end
        return e;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            busy = 1'b0; last = 1'b1; seen = 1'b0; hold = 1'b0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
            if (busy) begin
                if (bus.req0_valid | bus.req1_valid)
                    chk("no_ready_while_busy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            end else if (bus.req0_valid | bus.req1_valid) begin
                g_exp = (bus.req0_valid & bus.req1_valid) ? ~last : bus.req1_valid;
                chk("grant", 32'({bus.req1_ready, bus.req0_ready}), g_exp ? 32'd2 : 32'd1);
                if (g_exp) sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, cyc));
                else       sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, cyc));
                last = g_exp;
                busy = 1'b1;
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    flag("spurious_rsp_valid");
                end else begin
                    if (!seen) chk("rsp_latency", 32'(cyc), 32'(sb[0].due));
                    seen = 1'b1;
                    if (hold) begin
                        chk("held_q",   32'(bus.rsp_q),   32'(h_q));
                        chk("held_r",   32'(bus.rsp_r),   32'(h_r));
                        chk("held_id",  32'(bus.rsp_id),  32'(h_id));
                        chk("held_dbz", 32'(bus.rsp_dbz), 32'(h_dbz));
                    end
                    if (bus.rsp_ready) begin
                        chk("rsp_id",  32'(bus.rsp_id),  32'(sb[0].id));
                        chk("rsp_q",   32'(bus.rsp_q),   32'(sb[0].q));
                        chk("rsp_r",   32'(bus.rsp_r),   32'(sb[0].r));
                        chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(sb[0].dbz));
                        void'(sb.pop_front());
                        seen = 1'b0; hold = 1'b0; busy = 1'b0;
                    end else begin
                        hold = 1'b1;
                        h_q = bus.rsp_q; h_r = bus.rsp_r; h_id = bus.rsp_id; h_dbz = bus.rsp_dbz;
                    end
                end
            end else if (seen) begin
                flag("rsp_valid_dropped_before_handshake");
                seen = 1'b0; hold = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
            default: bus.rsp_ready = manual_rdy;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        if (n == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
        else        begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
        do begin
            tick(1);
            t++;
        end while (!((n == 0) ? acc0 : acc1) && t < 400);
        if (t >= 400) flag("accept_timeout");
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            tick(1);
            t++;
        end
        if (t >= 2000) flag("drain_timeout");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_q",     32'(bus.rsp_q),     32'd0);
        chk("reset_rsp_r",     32'(bus.rsp_r),     32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_rsp_dbz",   32'(bus.rsp_dbz),   32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        issue(0, 4'd9, 4'd4);
        drain();

        // Contention straight out of reset, both requesters kept busy.
        pulse_reset();
        fork
            begin issue(0, 4'd15, 4'd7); issue(0, 4'd3, 4'd2); end
            begin issue(1, 4'd8, 4'd5);  issue(1, 4'd7, 4'd7); end
        join
        drain();

        issue(1, 4'd6, 4'd0);
        drain();

        // Backpressure in DONE while req0 waits.
        rdy_mode = 2;
        manual_rdy = 1'b0;
        issue(0, 4'd11, 4'd3);
        fork
            issue(0, 4'd5, 4'd2);
            begin
                int t;
                t = 0;
                while (!bus.rsp_valid && t < 50) begin tick(1); t++; end
                if (t >= 50) flag("rsp_valid_timeout");
                tick(3);
                manual_rdy = 1'b1;
            end
        join
        drain();
        rdy_mode = 0;
        tick(1);

        // Reset mid-CALC discards the in-flight result.
        issue(0, 4'd9, 4'd2);
        tick(2);
        rst = 1'b1;
        #1;
        chk("rst_calc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_calc_rsp_q",     32'(bus.rsp_q),     32'd0);
        chk("rst_calc_rsp_r",     32'(bus.rsp_r),     32'd0);
        chk("rst_calc_rsp_id",    32'(bus.rsp_id),    32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        issue(0, 4'd9, 4'd3);
        drain();

        // Reset mid-DONE.
        rdy_mode = 2;
        manual_rdy = 1'b0;
        tick(1);
        issue(1, 4'd7, 4'd0);
        tick(2);
        rst = 1'b1;
        #1;
        chk("rst_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_done_rsp_dbz",   32'(bus.rsp_dbz),   32'd0);
        chk("rst_done_rsp_q",     32'(bus.rsp_q),     32'd0);
        tick(2);
        rst = 1'b0;
        rdy_mode = 0;
        tick(1);

        for (int a = 0; a < 16; a++) issue(a % 2, W'(a), 4'd3);
        drain();

        rdy_mode = 1;
        fork
            for (int i = 0; i < 40; i++) begin
                tick($urandom_range(0, 3));
                issue(0, W'($urandom_range(0, 15)),
                      ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(1, 15)));
            end
            for (int j = 0; j < 40; j++) begin
                tick($urandom_range(0, 3));
                issue(1, W'($urandom_range(0, 15)),
                      ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(1, 15)));
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
